// File: rtl/serial_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_pkg
// Brief    : Shared frame constants and FSM state type for the serial link.
// Revision : 1.0 - initial release
// ============================================================================
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        HEADER  = 2'd2,
        PAYLOAD = 2'd3
    } state_t;

    localparam int                   START_LEN = 4;
    localparam logic [START_LEN-1:0] START_SEQ = 4'b1101;
    localparam int                   HDR_W     = 8;

endpackage
`default_nettype wire

// File: rtl/tx_byte_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tx_byte_buffer
// Brief    : One-byte prefetch holding register with valid/ready handshake
//            and a count of payload bytes still to be fetched for the frame.
// Revision : 1.0 - initial release
// ============================================================================
module tx_byte_buffer #(
    parameter int HDR_W = serial_frame_pkg::HDR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [HDR_W-1:0] i_len,
    input  logic             i_active,
    input  logic             i_take,
    input  logic             i_clear,
    input  logic [7:0]       i_data,
    input  logic             i_data_valid,
    output logic             o_data_ready,
    output logic             o_full,
    output logic [7:0]       o_data
);

    // One extra bit so ceil((2**HDR_W-1)/8) fits without wrapping.
    localparam int FETCH_W = HDR_W - 2;

    logic [FETCH_W-1:0] r_fetch_left;
    logic               r_full;
    logic [7:0]         r_data;
    logic [FETCH_W-1:0] w_bytes_needed;
    logic               w_fetch;

    assign w_bytes_needed = {1'b0, i_len[HDR_W-1:3]} + FETCH_W'(|i_len[2:0]);
    assign o_data_ready   = ~r_full & (r_fetch_left != '0) & i_active;
    assign w_fetch        = i_data_valid & o_data_ready;
    assign o_full         = r_full;
    assign o_data         = r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full       <= 1'b0;
            r_data       <= '0;
            r_fetch_left <= '0;
        end else if (i_clear) begin
            r_full       <= 1'b0;
            r_fetch_left <= '0;
        end else if (i_load) begin
            r_full       <= 1'b0;
            r_fetch_left <= w_bytes_needed;
        end else if (w_fetch) begin
            r_full       <= 1'b1;
            r_data       <= i_data;
            r_fetch_left <= r_fetch_left - FETCH_W'(1);
        end else if (i_take) begin
            r_full       <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_tx
// Brief    : Serial frame transmitter: start sequence, length header, then
//            N payload bits drawn MSB first from a prefetched byte stream.
// Revision : 1.0 - initial release
// ============================================================================
module serial_frame_tx #(
    parameter int                   START_LEN  = serial_frame_pkg::START_LEN,
    parameter logic [START_LEN-1:0] START_SEQ  = serial_frame_pkg::START_SEQ,
    parameter int                   HDR_W      = serial_frame_pkg::HDR_W,
    parameter logic                 IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [HDR_W-1:0] len,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_out,
    output logic             ser_out_valid,
    output logic             busy,
    output logic             frame_done,
    output logic             underrun_err
);

    import serial_frame_pkg::*;

    localparam int HS_W = START_LEN + HDR_W;

    state_t           r_state;
    logic [HDR_W-1:0] r_cnt;
    logic [HDR_W-1:0] r_len;
    logic [HS_W-1:0]  r_hdr_sr;
    logic [7:0]       r_shift;
    logic [2:0]       r_byte_bits;
    logic             r_ser;
    logic             r_ser_valid;
    logic             r_busy;
    logic             r_done;
    logic             r_underrun;

    logic [HS_W-1:0]  w_seed;
    logic             w_boundary;
    logic             w_take;
    logic             w_underrun;
    logic             w_full;
    logic [7:0]       w_hold;

    // Start pattern and header leave through one shift register.
    assign w_seed     = {START_SEQ, len};
    assign w_boundary = ((r_state == HEADER)  && (r_cnt == '0) && (r_len != '0)) ||
                        ((r_state == PAYLOAD) && (r_cnt != '0) && (r_byte_bits == 3'd0));
    assign w_take     = w_boundary & w_full;
    assign w_underrun = w_boundary & ~w_full;

    tx_byte_buffer #(
        .HDR_W        (HDR_W)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .i_load       ((r_state == IDLE) && req),
        .i_len        (len),
        .i_active     (r_busy),
        .i_take       (w_take),
        .i_clear      (w_underrun),
        .i_data       (data_in),
        .i_data_valid (data_valid),
        .o_data_ready (data_ready),
        .o_full       (w_full),
        .o_data       (w_hold)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_len       <= '0;
            r_hdr_sr    <= '0;
            r_shift     <= '0;
            r_byte_bits <= '0;
            r_ser       <= IDLE_LEVEL;
            r_ser_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_state  <= START;
                        r_len    <= len;
                        r_cnt    <= HDR_W'(START_LEN - 1);
                        r_ser    <= w_seed[HS_W-1];
                        r_hdr_sr <= {w_seed[HS_W-2:0], 1'b0};
                        r_busy   <= 1'b1;
                    end
                end
                START: begin
                    r_ser    <= r_hdr_sr[HS_W-1];
                    r_hdr_sr <= {r_hdr_sr[HS_W-2:0], 1'b0};
                    if (r_cnt == '0) begin
                        r_state <= HEADER;
                        r_cnt   <= HDR_W'(HDR_W - 1);
                    end else begin
                        r_cnt   <= r_cnt - HDR_W'(1);
                    end
                end
                HEADER: begin
                    if (r_cnt != '0) begin
                        r_ser    <= r_hdr_sr[HS_W-1];
                        r_hdr_sr <= {r_hdr_sr[HS_W-2:0], 1'b0};
                        r_cnt    <= r_cnt - HDR_W'(1);
                    end else if (r_len == '0) begin
                        r_state <= IDLE;
                        r_ser   <= IDLE_LEVEL;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_full) begin
                        r_state     <= PAYLOAD;
                        r_cnt       <= r_len - HDR_W'(1);
                        r_ser       <= w_hold[7];
                        r_shift     <= {w_hold[6:0], 1'b0};
                        r_byte_bits <= 3'd7;
                        r_ser_valid <= 1'b1;
                    end else begin
                        r_state    <= IDLE;
                        r_ser      <= IDLE_LEVEL;
                        r_busy     <= 1'b0;
                        r_underrun <= 1'b1;
                    end
                end
                PAYLOAD: begin
                    if (r_cnt == '0) begin
                        r_state     <= IDLE;
                        r_ser       <= IDLE_LEVEL;
                        r_ser_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end else if (r_byte_bits != 3'd0) begin
                        r_ser       <= r_shift[7];
                        r_shift     <= {r_shift[6:0], 1'b0};
                        r_byte_bits <= r_byte_bits - 3'd1;
                        r_cnt       <= r_cnt - HDR_W'(1);
                    end else if (w_full) begin
                        r_ser       <= w_hold[7];
                        r_shift     <= {w_hold[6:0], 1'b0};
                        r_byte_bits <= 3'd7;
                        r_cnt       <= r_cnt - HDR_W'(1);
                    end else begin
                        // Byte boundary with nothing prefetched: drop the frame.
                        r_state     <= IDLE;
                        r_ser       <= IDLE_LEVEL;
                        r_ser_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_underrun  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ser_out       = r_ser;
    assign ser_out_valid = r_ser_valid;
    assign busy          = r_busy;
    assign frame_done    = r_done;
    assign underrun_err  = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_frame_tx
// Brief    : Self-checking bench for serial_frame_tx against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_frame_tx;

    logic       clk;
    logic       rst;
    logic       req;
    logic [7:0] len;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       ser_out;
    logic       ser_out_valid;
    logic       busy;
    logic       frame_done;
    logic       underrun_err;

    int         n_checks   = 0;
    int         n_fail     = 0;
    int         hs_count   = 0;
    bit         hs_pending = 0;
    logic [7:0] src_q[$];

    serial_frame_tx dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .len           (len),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .ser_out       (ser_out),
        .ser_out_valid (ser_out_valid),
        .busy          (busy),
        .frame_done    (frame_done),
        .underrun_err  (underrun_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Byte source: offers the head of src_q whenever it is non-empty.
    initial begin
        data_valid = 1'b0;
        data_in    = 8'h00;
        forever begin
            @(negedge clk);
            if (hs_pending) begin
                hs_count++;
                if (src_q.size() > 0) void'(src_q.pop_front());
            end
            if (src_q.size() > 0) begin
                data_valid = 1'b1;
                data_in    = src_q[0];
            end else begin
                data_valid = 1'b0;
                data_in    = 8'($urandom);
            end
            #1 hs_pending = data_valid && data_ready && !rst;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, want end before 500000 ns");
        $fatal(1, "watchdog expired");
    end

    // Expected per-cycle {ser_out, ser_out_valid, busy, frame_done, underrun_err}
    // from the cycle after accept up to and including the first idle cycle.
    function automatic void model_frame(input int n, input logic [7:0] bytes[$],
                                        output logic [4:0] exp[$]);
        logic [3:0] sseq;
        logic [7:0] hdr;
        logic [7:0] b;
        int         nb;
        sseq = 4'b1101;
        hdr  = 8'(n);
        nb   = (n < 8 * bytes.size()) ? n : 8 * bytes.size();
        exp.delete();
        for (int i = 3; i >= 0; i--) exp.push_back({sseq[i], 1'b0, 1'b1, 1'b0, 1'b0});
        for (int i = 7; i >= 0; i--) exp.push_back({hdr[i], 1'b0, 1'b1, 1'b0, 1'b0});
        for (int j = 0; j < nb; j++) begin
            b = bytes[j / 8];
            exp.push_back({b[7 - (j % 8)], 1'b1, 1'b1, 1'b0, 1'b0});
        end
        exp.push_back({1'b0, 1'b0, 1'b0, nb == n, nb != n});
    endfunction

    // Issues a request (caller is just past a falling edge) and records outputs.
    task automatic capture_frame(input int n, input logic [7:0] bytes[$], input int cycles,
                                 input bit noisy, output logic [4:0] obs[$],
                                 output bit ready_seen, output int hs_used);
        int hs0;
        hs0 = hs_count;
        obs.delete();
        ready_seen = 1'b0;
        foreach (bytes[i]) src_q.push_back(bytes[i]);
        req = 1'b1;
        len = 8'(n);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            obs.push_back({ser_out, ser_out_valid, busy, frame_done, underrun_err});
            if (data_ready) ready_seen = 1'b1;
            req = (noisy && c < 8) ? 1'($urandom) : 1'b0;
            len = 8'($urandom);
        end
        @(negedge clk);
        hs_used = hs_count - hs0;
    endtask

    task automatic test_reset();
        logic [7:0] bytes[$];
        @(negedge clk);
        n_checks++;
        if ({ser_out, ser_out_valid, busy, frame_done, underrun_err, data_ready} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_por: got %b want 000000",
                     {ser_out, ser_out_valid, busy, frame_done, underrun_err, data_ready});
        end
        rst = 1'b0;
        bytes = '{8'h11, 8'h22, 8'h33};
        foreach (bytes[i]) src_q.push_back(bytes[i]);
        req = 1'b1;
        len = 8'd20;
        repeat (6) begin
            @(negedge clk);
            req = 1'b0;
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_running: busy got %b want 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({ser_out, ser_out_valid, busy, frame_done, underrun_err, data_ready} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_async: got %b want 000000",
                     {ser_out, ser_out_valid, busy, frame_done, underrun_err, data_ready});
        end
        src_q.delete();
        hs_pending = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({ser_out, ser_out_valid, busy, frame_done, underrun_err, data_ready} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_idle: got %b want 000000",
                         {ser_out, ser_out_valid, busy, frame_done, underrun_err, data_ready});
            end
        end
    endtask

    task automatic test_len3();
        logic [7:0] bytes[$];
        logic [4:0] exp[$];
        logic [4:0] obs[$];
        bit         rs;
        int         hs;
        bytes = '{8'hA0};
        @(negedge clk);
        model_frame(3, bytes, exp);
        capture_frame(3, bytes, exp.size(), 1'b0, obs, rs, hs);
        foreach (exp[i]) begin
            n_checks++;
            if (obs[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL len3[%0d]: got %b want %b", i, obs[i], exp[i]);
            end
        end
        n_checks++;
        if (hs !== 1) begin
            n_fail++;
            $display("FAIL len3_handshakes: got %0d want 1", hs);
        end
    endtask

    task automatic test_len0();
        logic [7:0] bytes[$];
        logic [4:0] exp[$];
        logic [4:0] obs[$];
        bit         rs;
        int         hs;
        @(negedge clk);
        model_frame(0, bytes, exp);
        capture_frame(0, bytes, exp.size(), 1'b0, obs, rs, hs);
        foreach (exp[i]) begin
            n_checks++;
            if (obs[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL len0[%0d]: got %b want %b", i, obs[i], exp[i]);
            end
        end
        n_checks++;
        if (rs !== 1'b0 || hs !== 0) begin
            n_fail++;
            $display("FAIL len0_no_fetch: ready_seen %b handshakes %0d want 0 0", rs, hs);
        end
    endtask

    task automatic test_len16();
        logic [7:0] bytes[$];
        logic [4:0] exp[$];
        logic [4:0] obs[$];
        bit         rs;
        int         hs;
        bytes = '{8'h5A, 8'hC3};
        @(negedge clk);
        model_frame(16, bytes, exp);
        capture_frame(16, bytes, exp.size(), 1'b1, obs, rs, hs);
        foreach (exp[i]) begin
            n_checks++;
            if (obs[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL len16[%0d]: got %b want %b", i, obs[i], exp[i]);
            end
        end
        n_checks++;
        if (hs !== 2) begin
            n_fail++;
            $display("FAIL len16_handshakes: got %0d want 2", hs);
        end
    endtask

    task automatic test_underrun();
        logic [7:0] bytes[$];
        logic [4:0] exp[$];
        logic [4:0] obs[$];
        bit         rs;
        int         hs;
        bytes = '{8'h5A};
        @(negedge clk);
        model_frame(16, bytes, exp);
        capture_frame(16, bytes, exp.size(), 1'b0, obs, rs, hs);
        foreach (exp[i]) begin
            n_checks++;
            if (obs[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL underrun[%0d]: got %b want %b", i, obs[i], exp[i]);
            end
        end
        n_checks++;
        if (hs !== 1) begin
            n_fail++;
            $display("FAIL underrun_handshakes: got %0d want 1", hs);
        end
    endtask

    task automatic test_header_req_rst();
        logic [7:0] bytes[$];
        logic [4:0] exp[$];
        logic [4:0] obs[$];
        logic [4:0] cur;
        bit         rs;
        int         hs;
        bytes = '{8'h5A, 8'hC3};
        @(negedge clk);
        model_frame(16, bytes, exp);
        foreach (bytes[i]) src_q.push_back(bytes[i]);
        req = 1'b1;
        len = 8'd16;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            cur = {ser_out, ser_out_valid, busy, frame_done, underrun_err};
            n_checks++;
            if (cur !== exp[c]) begin
                n_fail++;
                $display("FAIL hdr_req_ignored[%0d]: got %b want %b", c, cur, exp[c]);
            end
            req = (c == 5);
            len = 8'($urandom);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({ser_out, ser_out_valid, busy, frame_done, underrun_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL hdr_rst_abort: got %b want 00000",
                     {ser_out, ser_out_valid, busy, frame_done, underrun_err});
        end
        src_q.delete();
        hs_pending = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bytes = '{8'($urandom), 8'($urandom)};
        model_frame(16, bytes, exp);
        capture_frame(16, bytes, exp.size(), 1'b0, obs, rs, hs);
        foreach (exp[i]) begin
            n_checks++;
            if (obs[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL hdr_rst_clean[%0d]: got %b want %b", i, obs[i], exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes[$];
        logic [4:0] exp[$];
        logic [4:0] obs[$];
        bit         rs;
        int         hs;
        int         lens[3];
        lens = '{9, 0, 24};
        @(negedge clk);
        // Each request lands in the previous frame's frame_done cycle.
        foreach (lens[f]) begin
            bytes.delete();
            for (int i = 0; i < (lens[f] + 7) / 8; i++) bytes.push_back(8'($urandom));
            model_frame(lens[f], bytes, exp);
            capture_frame(lens[f], bytes, exp.size() - 1, 1'b0, obs, rs, hs);
            for (int i = 0; i < exp.size() - 1; i++) begin
                n_checks++;
                if (obs[i] !== exp[i]) begin
                    n_fail++;
                    $display("FAIL b2b%0d[%0d]: got %b want %b", f, i, obs[i], exp[i]);
                end
            end
            n_checks++;
            if ({ser_out, ser_out_valid, busy, frame_done, underrun_err} !== 5'b00010) begin
                n_fail++;
                $display("FAIL b2b%0d_done: got %b want 00010", f,
                         {ser_out, ser_out_valid, busy, frame_done, underrun_err});
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] bytes[$];
        logic [4:0] exp[$];
        logic [4:0] obs[$];
        bit         rs;
        int         hs;
        int         n;
        int         k;
        int         specials[6];
        specials = '{1, 7, 8, 9, 255, 0};
        @(negedge clk);
        for (int t = 0; t < 24; t++) begin
            n = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 5)]
                                            : int'($urandom_range(0, 255));
            k = (n + 7) / 8;
            if (k > 0 && $urandom_range(0, 3) == 0) k = $urandom_range(0, k - 1);
            bytes.delete();
            for (int i = 0; i < k; i++) bytes.push_back(8'($urandom));
            model_frame(n, bytes, exp);
            capture_frame(n, bytes, exp.size(), 1'b1, obs, rs, hs);
            foreach (exp[i]) begin
                n_checks++;
                if (obs[i] !== exp[i]) begin
                    n_fail++;
                    $display("FAIL rand%0d n=%0d k=%0d [%0d]: got %b want %b",
                             t, n, k, i, obs[i], exp[i]);
                end
            end
            n_checks++;
            if (hs !== k) begin
                n_fail++;
                $display("FAIL rand%0d_handshakes: got %0d want %0d", t, hs, k);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 1'b0;
        len = 8'h00;
        test_reset();
        test_len3();
        test_len0();
        test_len16();
        test_underrun();
        test_header_req_rst();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
